// File: rtl/sfu_ctrl.sv
// Sequencer for the SFU accumulate stage: pops partial sums from the array
// output FIFO, steers SFU load/accumulate and writes each finished row to psum memory.
module sfu_ctrl #(
  parameter int TILE_BW = 8,
  parameter int ROW_BW  = 8,
  parameter int ADDR_BW = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [TILE_BW-1:0] num_tiles_i,
  input  logic [ROW_BW-1:0]  num_rows_i,
  input  logic [ADDR_BW-1:0] base_addr_i,
  input  logic               mode_i,
  input  logic               ofifo_valid_i,
  output logic               ofifo_rd_o,
  output logic               sfu_en_o,
  output logic               sfu_acc_o,
  output logic               sfu_mode_o,
  output logic               pmem_wen_o,
  output logic [ADDR_BW-1:0] pmem_addr_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [TILE_BW-1:0] TILE_ONE = TILE_BW'(1);
  localparam logic [ROW_BW-1:0]  ROW_ONE  = ROW_BW'(1);

  state_t             state;
  logic [TILE_BW-1:0] tile_cnt;
  logic [ROW_BW-1:0]  row_cnt;
  logic [TILE_BW-1:0] k_q;
  logic [ROW_BW-1:0]  r_q;
  logic [ADDR_BW-1:0] base_q;
  logic               mode_q;

  logic               pop;
  logic               last_tile;
  logic               last_row;

  // K and R are at least 1 whenever RUN/WB are reached, so K-1 / R-1 never wrap.
  assign pop       = (state == RUN) && ofifo_valid_i;
  assign last_tile = (tile_cnt == (k_q - TILE_ONE));
  assign last_row  = (row_cnt == (r_q - ROW_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tile_cnt <= '0;
      row_cnt  <= '0;
      k_q      <= '0;
      r_q      <= '0;
      base_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            k_q      <= num_tiles_i;
            r_q      <= num_rows_i;
            base_q   <= base_addr_i;
            mode_q   <= mode_i;
            tile_cnt <= '0;
            row_cnt  <= '0;
            if ((num_tiles_i == '0) || (num_rows_i == '0)) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop) begin
            if (last_tile) begin
              tile_cnt <= '0;
              state    <= WB;
            end else begin
              tile_cnt <= tile_cnt + TILE_ONE;
            end
          end
        end
        WB: begin
          if (last_row) begin
            state <= DONE;
          end else begin
            row_cnt <= row_cnt + ROW_ONE;
            state   <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the registered state; only the pop path sees the FIFO valid.
  assign ofifo_rd_o  = pop;
  assign sfu_en_o    = pop;
  assign sfu_acc_o   = (state == RUN) && (tile_cnt != '0);
  assign busy_o      = (state != IDLE);
  assign sfu_mode_o  = busy_o && mode_q;
  assign pmem_wen_o  = (state == WB);
  assign pmem_addr_o = (state == WB) ? (base_q + ADDR_BW'(row_cnt)) : '0;
  assign done_o      = (state == DONE);

endmodule

// File: doc/sfu_ctrl.md
Name: sfu_ctrl

Overview:
- Sequencer for the SFU accumulate stage of the systolic-array datapath.
- Pops partial-sum vectors from the array output FIFO (show-ahead, valid/read) and drives the SFU `acc_i`/`mode_i`/enable.
- After each output row has accumulated `num_tiles` partial sums, writes the SFU result to psum memory at `base_addr + row`.
- Started by the top-level controller; reports busy/done.

Parameters:
- TILE_BW, 8, width of the tile-count configuration.
- ROW_BW, 8, width of the row-count configuration.
- ADDR_BW, 11, psum memory address width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle start pulse; sampled only in IDLE.
- num_tiles_i  input  TILE_BW  partial sums per output row (K); latched on start.
- num_rows_i  input  ROW_BW  output rows to produce (R); latched on start.
- base_addr_i  input  ADDR_BW  first psum memory address; latched on start.
- mode_i  input  1  SFU mode (1 = ReLU, 0 = pass); latched on start.
- ofifo_valid_i  input  1  output FIFO head word is valid.
- ofifo_rd_o  output  1  pop FIFO head this cycle.
- sfu_en_o  output  1  SFU captures `psum_in` this cycle.
- sfu_acc_o  output  1  0 = load head word, 1 = add head word to the SFU register.
- sfu_mode_o  output  1  latched mode, driven to SFU `mode_i`.
- pmem_wen_o  output  1  psum memory write enable; data is the SFU `psum_out`.
- pmem_addr_o  output  ADDR_BW  psum memory write address.
- busy_o  output  1  high in any state except IDLE.
- done_o  output  1  one-cycle pulse on job completion.

Behaviour:
- States: IDLE, RUN, WB, DONE.
- Registers:
  - tile_cnt (TILE_BW), row_cnt (ROW_BW).
  - Latched K, R, base, mode.
- Reset: state = IDLE; all counters and latches = 0.
  - All outputs are 0 during and after reset: ofifo_rd_o, sfu_en_o, sfu_acc_o, sfu_mode_o, pmem_wen_o, pmem_addr_o, busy_o, done_o.
- IDLE:
  - start_i = 1 latches the configuration and clears both counters.
  - If K == 0 or R == 0, next state is DONE: no pops, no writes.
  - Otherwise next state is RUN.
- RUN (combinational outputs, decoded from registered state):
  - pop = ofifo_valid_i; ofifo_rd_o = sfu_en_o = pop.
  - sfu_acc_o = (tile_cnt != 0), driven every RUN cycle.
  - If pop and tile_cnt == K-1: tile_cnt <= 0, next state is WB.
  - Else if pop: tile_cnt increments.
  - If no pop: hold state and counters. The SFU holds its register because sfu_en_o = 0.
- WB (exactly one cycle):
  - pmem_wen_o = 1; pmem_addr_o = base + row_cnt, truncated to ADDR_BW (wraps modulo 2^ADDR_BW).
  - The SFU result is valid, since it registered on the last pop edge.
  - No pop in WB: ofifo_rd_o = 0 even if ofifo_valid_i = 1.
  - If row_cnt == R-1, next state is DONE; else row_cnt increments and next state is RUN.
- DONE (one cycle): done_o = 1; next state is IDLE.
- pmem_addr_o is 0 outside WB. sfu_mode_o = latched mode whenever busy_o = 1, else 0.
- Job length with a never-empty FIFO: 1 + R·(K+1) cycles from the cycle after start to done_o inclusive.
  - Row write cadence is K+1 cycles.
- start_i while busy is ignored: no relatch, no restart.
- Reset asserted mid-job: return to IDLE next edge.
  - Any pending write is dropped; no done_o.
  - Words already popped are lost; the FIFO flush is the owner's responsibility.
- Counter width rule: K = 2^TILE_BW − 1 and R = 2^ROW_BW − 1 are legal maxima. Compares are exact, with no off-by-one overflow.

Test Plan:
- K=3, R=2, base=0x010, mode=1, FIFO always valid.
  - ofifo_rd_o pattern 1,1,1,0,1,1,1,0; sfu_acc_o on pops 0,1,1 | 0,1,1.
  - pmem_wen_o at cycles 4 and 8 after start with addr 0x010, 0x011.
  - done_o at cycle 9; sfu_mode_o = 1 while busy.
- Same job with ofifo_valid_i toggling 1,0,0,1,0,1,1,1,…
  - Pops only on valid; sfu_acc_o sequence and write addresses are identical to the first scenario.
  - No write occurs before the third pop of each row.
- K=0, R=5 start → done_o next cycle; zero pops, zero writes. Repeat with K=4, R=0 → same.
- K=1, R=3, base=0x7FE (ADDR_BW=11).
  - sfu_acc_o = 0 on every pop.
  - Writes to 0x7FE, 0x7FF, 0x000 (wrap).
- start_i pulsed again with different K, R mid-job → ignored; original write count and addresses produced.
  - Reset asserted during RUN after 2 pops → IDLE; outputs 0; no done_o.
  - A fresh start then runs cleanly from tile 0, row 0.
